text_console_writer: RTL and testbench

//   Bus initiator driving the frame buffer's asynchronous display-RAM port (address/data/cs_n/oe_n/we_n).

---
 rtl/text_console_writer.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_text_console_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// -----------------------------------------------------------------------------
// text_console_writer
//   Bus initiator that renders a byte stream as a text terminal on an
//   asynchronous display RAM. Printable bytes are written at the cursor.
//   CR, LF, BS and FF move the cursor or clear the screen. Writing past the
//   last column wraps to the next line. A line feed on the last row scrolls
//   the screen: every row is copied up one row by a read and then a write,
//   and the last row is then filled with the blank character.
//
// Ports
//   i_clock        host clock, all logic on the rising edge
//   i_reset        synchronous active-high reset
//   i_in_data      character or control byte
//   i_in_valid     i_in_data is valid
//   o_in_ready     a byte can be accepted (only while idle)
//   o_address      display RAM address
//   io_data        display RAM data, driven only during write accesses
//   o_cs_n         chip select, active low
//   o_oe_n         read strobe, active low
//   o_we_n         write strobe, active low
//   o_cursor_col   cursor column, 0..DISP_W-1
//   o_cursor_row   cursor row, 0..DISP_H-1
//   o_busy         a byte is being processed or a bus sequence is running
// -----------------------------------------------------------------------------
module text_console_writer #(
   parameter int         DISP_W         = 80,
   parameter int         DISP_H         = 25,
   parameter int         ASIZE          = 11,
   parameter int         SETUP_CYCLES   = 1,
   parameter int         STROBE_CYCLES  = 4,
   parameter int         HOLD_CYCLES    = 1,
   parameter logic [7:0] BLANK_CHAR     = 8'h20,
   parameter bit         CLEAR_ON_RESET = 1'b1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [7:0]       i_in_data,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic [ASIZE-1:0] o_address,
   inout  wire  [7:0]       io_data,
   output logic             o_cs_n,
   output logic             o_oe_n,
   output logic             o_we_n,
   output logic [6:0]       o_cursor_col,
   output logic [4:0]       o_cursor_row,
   output logic             o_busy
);

   localparam logic [ASIZE-1:0] A_W        = ASIZE'(DISP_W);
   localparam logic [ASIZE-1:0] A_LAST     = ASIZE'(DISP_W * DISP_H - 1);
   localparam logic [ASIZE-1:0] A_SCR_LAST = ASIZE'(DISP_W * (DISP_H - 1) - 1);
   localparam logic [6:0]       COL_LAST   = 7'(DISP_W - 1);
   localparam logic [4:0]       ROW_LAST   = 5'(DISP_H - 1);
   localparam logic [7:0]       C_SETUP    = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0]       C_STROBE   = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0]       C_HOLD     = 8'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_SETUP, S_STROBE, S_HOLD, S_GAP
   } state_t;

   typedef enum logic [1:0] {
      Q_PUT, Q_SCROLL_RD, Q_SCROLL_WR, Q_FILL
   } seq_t;

   state_t           r_state;
   seq_t             r_seq;
   logic [7:0]       r_byte;
   logic [6:0]       r_col;
   logic [4:0]       r_row;
   logic [ASIZE-1:0] r_row_base;   // r_row * DISP_W, kept incrementally
   logic [ASIZE-1:0] r_idx;        // scroll destination cell or fill cell
   logic [ASIZE-1:0] r_addr;
   logic [7:0]       r_wdata;
   logic             r_drive;
   logic             r_cs_n;
   logic             r_oe_n;
   logic             r_we_n;
   logic [7:0]       r_cnt;
   logic [7:0]       r_rd_data;
   logic             r_home;       // sequence came from FF: cursor to (0,0)
   logic             r_wrap;       // scroll came from a line wrap: column to 0
   logic             r_ready;
   logic             r_busy;

   // Next access to launch, if any, from DECODE or from the gap cycle.
   logic             w_go;
   seq_t             w_go_seq;
   logic [ASIZE-1:0] w_go_addr;
   logic [ASIZE-1:0] w_go_idx;
   logic [7:0]       w_go_data;
   logic [ASIZE-1:0] w_put_addr;
   logic [ASIZE-1:0] w_idx_inc;

   assign w_put_addr = r_row_base + ASIZE'(r_col);
   assign w_idx_inc  = r_idx + 1'b1;

   always_comb begin
      w_go      = 1'b0;
      w_go_seq  = Q_PUT;
      w_go_addr = '0;
      w_go_idx  = '0;
      w_go_data = BLANK_CHAR;
      case (r_state)
         S_DECODE: begin
            case (r_byte)
               8'h0D, 8'h08: ;
               8'h0A: begin
                  if (r_row == ROW_LAST) begin
                     w_go      = 1'b1;
                     w_go_seq  = Q_SCROLL_RD;
                     w_go_addr = A_W;
                  end
               end
               8'h0C: begin
                  w_go     = 1'b1;
                  w_go_seq = Q_FILL;
               end
               default: begin
                  w_go      = 1'b1;
                  w_go_seq  = Q_PUT;
                  w_go_addr = w_put_addr;
                  w_go_data = r_byte;
               end
            endcase
         end
         S_GAP: begin
            case (r_seq)
               Q_PUT: begin
                  // Wrapping off the bottom-right cell starts a scroll.
                  if (r_col == COL_LAST && r_row == ROW_LAST) begin
                     w_go      = 1'b1;
                     w_go_seq  = Q_SCROLL_RD;
                     w_go_addr = A_W;
                  end
               end
               Q_SCROLL_RD: begin
                  w_go      = 1'b1;
                  w_go_seq  = Q_SCROLL_WR;
                  w_go_addr = r_idx;
                  w_go_idx  = r_idx;
                  w_go_data = r_rd_data;
               end
               Q_SCROLL_WR: begin
                  w_go     = 1'b1;
                  w_go_idx = w_idx_inc;
                  if (r_idx == A_SCR_LAST) begin
                     w_go_seq  = Q_FILL;
                     w_go_addr = w_idx_inc;
                  end else begin
                     w_go_seq  = Q_SCROLL_RD;
                     w_go_addr = w_idx_inc + A_W;
                  end
               end
               default: begin
                  // Both fills (FF and scroll blanking) end at the last cell.
                  if (r_idx != A_LAST) begin
                     w_go      = 1'b1;
                     w_go_seq  = Q_FILL;
                     w_go_addr = w_idx_inc;
                     w_go_idx  = w_idx_inc;
                  end
               end
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= CLEAR_ON_RESET ? S_DECODE : S_IDLE;
         r_seq      <= Q_PUT;
         r_byte     <= 8'h0C;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_idx      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_drive    <= 1'b0;
         r_cs_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_cnt      <= '0;
         r_rd_data  <= '0;
         r_home     <= 1'b0;
         r_wrap     <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= CLEAR_ON_RESET;
      end else begin
         if (w_go) begin
            r_state <= S_SETUP;
            r_seq   <= w_go_seq;
            r_addr  <= w_go_addr;
            r_idx   <= w_go_idx;
            r_wdata <= w_go_data;
            r_drive <= (w_go_seq != Q_SCROLL_RD);
            r_cs_n  <= 1'b0;
            r_cnt   <= C_SETUP;
         end
         case (r_state)
            S_IDLE: begin
               if (i_in_valid && r_ready) begin
                  r_byte  <= i_in_data;
                  r_state <= S_DECODE;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DECODE: begin
               r_home <= (r_byte == 8'h0C);
               r_wrap <= 1'b0;
               case (r_byte)
                  8'h0D: begin
                     r_col   <= '0;
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end
                  8'h08: begin
                     if (r_col != '0)
                        r_col <= r_col - 7'd1;
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end
                  8'h0A: begin
                     if (r_row != ROW_LAST) begin
                        r_row      <= r_row + 5'd1;
                        r_row_base <= r_row_base + A_W;
                        r_state    <= S_IDLE;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_state <= S_STROBE;
                  r_cnt   <= C_STROBE;
                  if (r_seq == Q_SCROLL_RD)
                     r_oe_n <= 1'b0;
                  else
                     r_we_n <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_STROBE: begin
               if (r_cnt == '0) begin
                  if (r_seq == Q_SCROLL_RD)
                     r_rd_data <= io_data;
                  r_oe_n  <= 1'b1;
                  r_we_n  <= 1'b1;
                  r_state <= S_HOLD;
                  r_cnt   <= C_HOLD;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_cs_n  <= 1'b1;
                  r_drive <= 1'b0;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_GAP: begin
               if (w_go) begin
                  if (r_seq == Q_PUT)
                     r_wrap <= 1'b1;
               end else begin
                  // Whole sequence done: commit the cursor move now.
                  case (r_seq)
                     Q_PUT: begin
                        if (r_col != COL_LAST) begin
                           r_col <= r_col + 7'd1;
                        end else begin
                           r_col      <= '0;
                           r_row      <= r_row + 5'd1;
                           r_row_base <= r_row_base + A_W;
                        end
                     end
                     Q_FILL: begin
                        if (r_home) begin
                           r_col      <= '0;
                           r_row      <= '0;
                           r_row_base <= '0;
                        end else if (r_wrap) begin
                           r_col <= '0;
                        end
                     end
                     default: ;
                  endcase
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_data      = r_drive ? r_wdata : 8'hzz;
   assign o_address    = r_addr;
   assign o_cs_n       = r_cs_n;
   assign o_oe_n       = r_oe_n;
   assign o_we_n       = r_we_n;
   assign o_cursor_col = r_col;
   assign o_cursor_row = r_row;
   assign o_in_ready   = r_ready;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_text_console_writer.sv
// -----------------------------------------------------------------------------
// tb_text_console_writer
//   Drives bytes into text_console_writer, models the display RAM on the bus,
//   and compares every bus access and every cursor position against a
//   screen-level model of the terminal.
// -----------------------------------------------------------------------------
module tb_text_console_writer;

   localparam int W = 80;
   localparam int H = 25;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] addr;
   wire  [7:0]  bus;
   logic        cs_n, oe_n, we_n;
   logic [6:0]  col;
   logic [4:0]  row;
   logic        busy;

   text_console_writer dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_in_data    (in_data),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .o_address    (addr),
      .io_data      (bus),
      .o_cs_n       (cs_n),
      .o_oe_n       (oe_n),
      .o_we_n       (we_n),
      .o_cursor_col (col),
      .o_cursor_row (row),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   // Display RAM: answers reads combinationally, takes writes of complete accesses.
   logic [7:0] mem [0:2047];
   assign bus = (!cs_n && !oe_n) ? mem[addr] : 8'hzz;

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;
   int n_tx  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- screen-level reference model ----------------
   typedef struct { bit wr; int a; int d; } acc_t;
   acc_t q[$];
   int   sc [0:W*H-1];
   int   m_col = 0;
   int   m_row = 0;

   function automatic void push(bit wr, int a, int d);
      acc_t e;
      e.wr = wr; e.a = a; e.d = d;
      q.push_back(e);
   endfunction

   function automatic void model_scroll();
      for (int n = 0; n < W*(H-1); n++) begin
         push(1'b0, n + W, sc[n+W]);
         push(1'b1, n, sc[n+W]);
         sc[n] = sc[n+W];
      end
      for (int n = W*(H-1); n < W*H; n++) begin
         push(1'b1, n, 32'h20);
         sc[n] = 32'h20;
      end
   endfunction

   function automatic void model_byte(int b);
      case (b)
         8'h0D: m_col = 0;
         8'h08: if (m_col > 0) m_col--;
         8'h0A: if (m_row < H-1) m_row++; else model_scroll();
         8'h0C: begin
            for (int i = 0; i < W*H; i++) begin
               push(1'b1, i, 32'h20);
               sc[i] = 32'h20;
            end
            m_col = 0;
            m_row = 0;
         end
         default: begin
            push(1'b1, m_row*W + m_col, b);
            sc[m_row*W + m_col] = b;
            if (m_col == W-1) begin
               m_col = 0;
               if (m_row < H-1) m_row++; else model_scroll();
            end else begin
               m_col++;
            end
         end
      endcase
   endfunction

   // ---------------- bus monitor / compare process ----------------
   bit   mon_in_acc = 1'b0;
   int   mon_cyc, mon_wcnt, mon_rcnt, mon_first, mon_last;
   bit   mon_astable, mon_dstable;
   logic [10:0] mon_a;
   logic [7:0]  mon_d0, mon_rd;

   always @(negedge clk) begin
      if (rst) begin
         mon_in_acc = 1'b0;
      end else begin
         chk("busy_vs_ready", int'(busy), int'(!in_ready));
         if (!cs_n) begin
            if (!mon_in_acc) begin
               mon_in_acc  = 1'b1;
               mon_cyc     = 0;
               mon_wcnt    = 0;
               mon_rcnt    = 0;
               mon_first   = -1;
               mon_last    = -1;
               mon_a       = addr;
               mon_d0      = bus;
               mon_rd      = 8'h00;
               mon_astable = 1'b1;
               mon_dstable = 1'b1;
            end
            if (addr !== mon_a) mon_astable = 1'b0;
            if (oe_n && bus !== mon_d0) mon_dstable = 1'b0;
            if (!we_n || !oe_n) begin
               if (mon_first < 0) mon_first = mon_cyc;
               mon_last = mon_cyc;
            end
            if (!we_n) mon_wcnt++;
            if (!oe_n) begin
               mon_rcnt++;
               mon_rd = bus;
            end
            mon_cyc++;
         end else if (mon_in_acc) begin
            bit wr;
            int d;
            int key_act, key_exp;
            acc_t e;
            mon_in_acc = 1'b0;
            n_acc++;
            wr = (mon_wcnt > 0);
            d  = wr ? int'(mon_d0) : int'(mon_rd);
            chk("access_shape",
                mon_cyc*10000 + mon_wcnt*1000 + mon_rcnt*100 + mon_first*10 + mon_last,
                60000 + (wr ? 4000 : 400) + 14);
            chk("access_stable", int'(mon_astable && (!wr || mon_dstable)), 1);
            key_act = (int'(wr) << 20) | (int'(mon_a) << 8) | d;
            if (q.size() == 0) begin
               chk("unexpected_access", key_act, -1);
            end else begin
               e = q.pop_front();
               key_exp = (int'(e.wr) << 20) | (e.a << 8) | e.d;
               chk("access", key_act, key_exp);
            end
            if (wr) mem[mon_a] = mon_d0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (in_ready && q.size() == 0) break;
      end
      chk("idle_within_budget", int'(i < budget), 1);
      chk("cursor", int'(col)*100 + int'(row), m_col*100 + m_row);
   endtask

   task automatic send(input logic [7:0] b);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      chk("ready_before_send", int'(i < 200), 1);
      in_data  = b;
      in_valid = 1'b1;
      model_byte(int'(b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("ready_drop", int'(in_ready), 0);
      n_tx++;
      $display("tx %0d: byte 0x%02h -> model cursor (%0d,%0d), %0d accesses queued",
               n_tx, b, m_col, m_row, q.size());
   endtask

   function automatic logic [7:0] rand_char();
      return 8'($urandom_range(33, 126));
   endfunction

   // Global watchdog on total simulated cycles.
   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_before;
      int a_old, v_old;
      logic [7:0] b;

      // 1. Reset and clear-on-reset.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", int'(cs_n), 1);
      chk("rst_oe_n", int'(oe_n), 1);
      chk("rst_we_n", int'(we_n), 1);
      chk("rst_addr", int'(addr), 0);
      chk("rst_cursor", int'(col)*100 + int'(row), 0);
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 1);
      q.delete();
      m_col = 0;
      m_row = 0;
      model_byte(8'h0C);
      @(negedge clk);
      rst = 1'b0;
      wait_idle(20000);
      chk("clear_mem0", int'(mem[0]), 8'h20);
      chk("clear_mem1999", int'(mem[1999]), 8'h20);
      chk("clear_ready", int'(in_ready), 1);

      // 2. Single character at home.
      send(8'h41);
      wait_idle(100);
      chk("put_mem0", int'(mem[0]), 8'h41);
      chk("put_cursor", int'(col)*100 + int'(row), 100);

      // 3. Fill up to (79,5), then a write at the end of that row wraps.
      for (int i = 0; i < 478; i++) begin
         send(rand_char());
         wait_idle(100);
      end
      chk("pre_wrap_cursor", int'(col)*100 + int'(row), 7905);
      send(8'h42);
      wait_idle(100);
      chk("wrap_mem479", int'(mem[479]), 8'h42);
      chk("wrap_cursor", int'(col)*100 + int'(row), 6);

      // 4. Move to (10,24) and line-feed into a scroll.
      for (int i = 0; i < 18; i++) begin
         send(8'h0A);
         wait_idle(100);
      end
      for (int i = 0; i < 10; i++) begin
         send(8'h61 + 8'(i));
         wait_idle(100);
      end
      chk("pre_scroll_cursor", int'(col)*100 + int'(row), 1024);
      send(8'h0A);
      wait_idle(30000);
      chk("scroll_cursor", int'(col)*100 + int'(row), 1024);
      chk("scroll_mem399", int'(mem[399]), 8'h42);
      chk("scroll_mem1840", int'(mem[1840]), 8'h61);
      chk("scroll_mem1920", int'(mem[1920]), 8'h20);
      chk("scroll_mem1999", int'(mem[1999]), 8'h20);

      // 5. CR / BS produce no bus activity.
      send(8'h0D);
      wait_idle(100);
      acc_before = n_acc;
      send(8'h08);
      wait_idle(100);
      chk("bs_at_col0_cursor", int'(col)*100 + int'(row), 24);
      chk("bs_no_access", n_acc - acc_before, 0);
      for (int i = 0; i < 37; i++) begin
         send(rand_char());
         wait_idle(100);
      end
      chk("pre_cr_cursor", int'(col)*100 + int'(row), 3724);
      acc_before = n_acc;
      send(8'h0D);
      wait_idle(100);
      chk("cr_cursor", int'(col)*100 + int'(row), 24);
      chk("cr_no_access", n_acc - acc_before, 0);

      // Randomized mix from a freshly cleared screen, kept clear of scrolling.
      send(8'h0C);
      wait_idle(20000);
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 9))
            0: b = 8'h0D;
            1: b = 8'h08;
            2: b = 8'h0A;
            default: b = rand_char();
         endcase
         if (m_row >= 22 && (b == 8'h0A || (b != 8'h0D && b != 8'h08 && m_col == W-1)))
            b = 8'h0D;
         send(b);
         wait_idle(100);
      end

      // 6. Reset during a write strobe aborts the access.
      a_old = m_row*W + m_col;
      v_old = int'(mem[a_old]);
      send(8'h5A);
      for (int i = 0; i < 20; i++) begin
         if (!we_n) break;
         @(negedge clk);
      end
      chk("strobe_seen", int'(we_n), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_cs_n", int'(cs_n), 1);
      chk("abort_we_n", int'(we_n), 1);
      chk("abort_oe_n", int'(oe_n), 1);
      chk("abort_bus_released", int'(bus !== 8'h5A), 1);
      chk("abort_cursor", int'(col)*100 + int'(row), 0);
      chk("abort_ready", int'(in_ready), 0);
      chk("abort_no_write", int'(mem[a_old]), v_old);
      q.delete();
      m_col = 0;
      m_row = 0;
      model_byte(8'h0C);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("post_reset_clear_started", int'(n_acc > 0), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
